// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet transmit scheduler.
// Holds the FSM state encoding, counter/datapath widths, the default
// values of the scheduler parameters and a grant-select helper.
package eth_pkg;

    localparam int unsigned LEN_W  = 11;
    localparam int unsigned CNT_W  = 11;
    localparam int unsigned BYTE_W = 8;

    localparam int unsigned MIN_LEN_DEF   = 46;
    localparam int unsigned MAX_LEN_DEF   = 1500;
    localparam int unsigned IPG_CYC_DEF   = 48;
    localparam int unsigned START_TMO_DEF = 1024;

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        PAD,
        COMMIT,
        WAIT_START,
        WAIT_END,
        IPG
    } state_t;

    // One-hot requester vector for a granted requester index.
    function automatic logic [1:0] sel_onehot(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/eth_rr_arb.sv
// Two-input round-robin arbiter.
// Ports:
//   Clk, Rstn - Eth_Clk domain clock, async active-low reset
//   Req[1:0]  - request vector
//   Adv       - accept the current grant and move priority past it
//   Gnt[1:0]  - one-hot grant, decoded directly from Req and the pointer
module eth_rr_arb (
    input  logic       Clk,
    input  logic       Rstn,
    input  logic [1:0] Req,
    input  logic       Adv,
    output logic [1:0] Gnt
);

    // Index of the requester granted last; reset value 1 favours requester 0.
    logic last_q;

    // On contention the requester not granted last wins.
    always_comb begin
        Gnt = Req;
        if (Req == 2'b11) begin
            Gnt = last_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            last_q <= 1'b1;
        end else if (Adv && (Gnt != 2'b00)) begin
            last_q <= Gnt[1];
        end
    end

endmodule

// File: rtl/eth_tx_sched.sv
// Ethernet transmit scheduler: arbitrates two packet requesters, streams
// the granted packet bytewise to eth_tx (zero-padding short frames),
// commits the frame, tracks line activity and enforces the inter-packet gap.
// Ports:
//   Clk, Rstn             - Eth_Clk domain clock, async active-low reset
//   Req0/1, Len0/1        - packet requests and lengths (length sampled at grant)
//   Rd0/1, Byte0/1        - FWFT read strobes and data from each requester
//   Tx_En                 - line-active indication from eth_tx
//   Eth_Byte(_Valid)      - byte stream to eth_tx
//   Eth_Pkt_Rdy           - one-cycle frame commit pulse
//   Done, Err             - per-requester completion / error pulses
//   Busy                  - high whenever the scheduler is not idle
module eth_tx_sched
    import eth_pkg::*;
#(
    parameter int unsigned MIN_LEN   = MIN_LEN_DEF,
    parameter int unsigned MAX_LEN   = MAX_LEN_DEF,
    parameter int unsigned IPG_CYC   = IPG_CYC_DEF,
    parameter int unsigned START_TMO = START_TMO_DEF
) (
    input  logic              Clk,
    input  logic              Rstn,
    input  logic              Req0,
    input  logic              Req1,
    input  logic [LEN_W-1:0]  Len0,
    input  logic [LEN_W-1:0]  Len1,
    output logic              Rd0,
    output logic              Rd1,
    input  logic [BYTE_W-1:0] Byte0,
    input  logic [BYTE_W-1:0] Byte1,
    input  logic              Tx_En,
    output logic [BYTE_W-1:0] Eth_Byte,
    output logic              Eth_Byte_Valid,
    output logic              Eth_Pkt_Rdy,
    output logic [1:0]        Done,
    output logic [1:0]        Err,
    output logic              Busy
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [LEN_W-1:0]   len_q, len_d, len_in;
    logic               gsel_q, gsel_d;
    logic [1:0]         rd_q, rd_d;
    logic [BYTE_W-1:0]  eth_byte_q, eth_byte_d, byte_sel;
    logic               eth_valid_q, eth_valid_d;
    logic               pkt_rdy_q, pkt_rdy_d;
    logic [1:0]         done_q, done_d;
    logic [1:0]         err_q, err_d;
    logic               busy_q, busy_d;
    logic [1:0]         gnt;
    logic               arb_go;
    logic               len_bad;

    // Grants are held off while an error pulse is out so the failing
    // requester has a cycle to withdraw its request.
    assign arb_go  = (state_q == IDLE) && (gnt != 2'b00) && (err_q == 2'b00);
    assign len_in  = gnt[1] ? Len1 : Len0;
    assign len_bad = (len_in == '0) || (len_in > LEN_W'(MAX_LEN));
    assign byte_sel = gsel_q ? Byte1 : Byte0;
    assign cnt_inc  = cnt_q + CNT_W'(1);

    eth_rr_arb u_arb (
        .Clk  (Clk),
        .Rstn (Rstn),
        .Req  ({Req1, Req0}),
        .Adv  (arb_go),
        .Gnt  (gnt)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        gsel_d      = gsel_q;
        rd_d        = 2'b00;
        eth_byte_d  = '0;
        eth_valid_d = 1'b0;
        pkt_rdy_d   = 1'b0;
        done_d      = 2'b00;
        err_d       = 2'b00;

        case (state_q)
            IDLE: begin
                if (arb_go) begin
                    gsel_d = gnt[1];
                    len_d  = len_in;
                    cnt_d  = '0;
                    if (len_bad) begin
                        err_d = gnt;
                    end else begin
                        state_d = STREAM;
                        rd_d    = gnt;
                    end
                end
            end
            STREAM: begin
                eth_byte_d  = byte_sel;
                eth_valid_d = 1'b1;
                cnt_d       = cnt_inc;
                if (cnt_inc == len_q) begin
                    state_d = (len_q < LEN_W'(MIN_LEN)) ? PAD : COMMIT;
                end else begin
                    rd_d = sel_onehot(gsel_q);
                end
            end
            PAD: begin
                // Byte count continues from Len up to MIN_LEN.
                eth_valid_d = 1'b1;
                cnt_d       = cnt_inc;
                if (cnt_inc == CNT_W'(MIN_LEN)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                pkt_rdy_d = 1'b1;
                cnt_d     = '0;
                state_d   = WAIT_START;
            end
            WAIT_START: begin
                if (Tx_En) begin
                    state_d = WAIT_END;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(START_TMO)) begin
                        err_d   = sel_onehot(gsel_q);
                        cnt_d   = '0;
                        state_d = IPG;
                    end
                end
            end
            WAIT_END: begin
                if (!Tx_En) begin
                    done_d  = sel_onehot(gsel_q);
                    cnt_d   = '0;
                    state_d = IPG;
                end
            end
            IPG: begin
                cnt_d = cnt_inc;
                if (cnt_inc == CNT_W'(IPG_CYC)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            gsel_q      <= 1'b0;
            rd_q        <= 2'b00;
            eth_byte_q  <= '0;
            eth_valid_q <= 1'b0;
            pkt_rdy_q   <= 1'b0;
            done_q      <= 2'b00;
            err_q       <= 2'b00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            gsel_q      <= gsel_d;
            rd_q        <= rd_d;
            eth_byte_q  <= eth_byte_d;
            eth_valid_q <= eth_valid_d;
            pkt_rdy_q   <= pkt_rdy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign Rd0            = rd_q[0];
    assign Rd1            = rd_q[1];
    assign Eth_Byte       = eth_byte_q;
    assign Eth_Byte_Valid = eth_valid_q;
    assign Eth_Pkt_Rdy    = pkt_rdy_q;
    assign Done           = done_q;
    assign Err            = err_q;
    assign Busy           = busy_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Directed testbench for eth_tx_sched with default parameters.
module tb_eth_tx_sched;

    logic        Clk = 1'b0;
    logic        Rstn;
    logic        Req0, Req1;
    logic [10:0] Len0, Len1;
    logic        Rd0, Rd1;
    logic [7:0]  Byte0, Byte1;
    logic        Tx_En;
    logic [7:0]  Eth_Byte;
    logic        Eth_Byte_Valid;
    logic        Eth_Pkt_Rdy;
    logic [1:0]  Done, Err;
    logic        Busy;

    always #5 Clk = ~Clk;

    eth_tx_sched dut (
        .Clk            (Clk),
        .Rstn           (Rstn),
        .Req0           (Req0),
        .Req1           (Req1),
        .Len0           (Len0),
        .Len1           (Len1),
        .Rd0            (Rd0),
        .Rd1            (Rd1),
        .Byte0          (Byte0),
        .Byte1          (Byte1),
        .Tx_En          (Tx_En),
        .Eth_Byte       (Eth_Byte),
        .Eth_Byte_Valid (Eth_Byte_Valid),
        .Eth_Pkt_Rdy    (Eth_Pkt_Rdy),
        .Done           (Done),
        .Err            (Err),
        .Busy           (Busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // FWFT sources: requester 0 supplies 1,2,3..., requester 1 supplies 101,102,...
    int rd0_pos = 0, rd1_pos = 0;
    int base0 = 0, base1 = 0;
    always @(posedge Clk) begin
        if (Rd0) rd0_pos <= rd0_pos + 1;
        if (Rd1) rd1_pos <= rd1_pos + 1;
    end
    assign Byte0 = 8'(rd0_pos - base0 + 1);
    assign Byte1 = 8'(rd1_pos - base1 + 101);

    // Passive recorder of DUT activity, sampled on the falling edge.
    int cyc = 0;
    int rd0_cnt = 0, rd1_cnt = 0, both_rd = 0;
    int pkt_cnt = 0, pkt_cyc = 0;
    int err0_cnt = 0, err1_cnt = 0, err_cyc = 0;
    int done0_cnt = 0, done1_cnt = 0;
    logic [7:0] out_q[$];
    int vcyc_q[$];
    int gnt_hist[$];
    int rise_cyc[$];
    int done_cyc_q[$];
    logic p_rd0 = 1'b0, p_rd1 = 1'b0;

    always @(negedge Clk) begin
        cyc = cyc + 1;
        if (Rd0) rd0_cnt = rd0_cnt + 1;
        if (Rd1) rd1_cnt = rd1_cnt + 1;
        if (Rd0 && Rd1) both_rd = both_rd + 1;
        if (Rd0 && !p_rd0) begin gnt_hist.push_back(0); rise_cyc.push_back(cyc); end
        if (Rd1 && !p_rd1) begin gnt_hist.push_back(1); rise_cyc.push_back(cyc); end
        p_rd0 = Rd0;
        p_rd1 = Rd1;
        if (Eth_Byte_Valid) begin out_q.push_back(Eth_Byte); vcyc_q.push_back(cyc); end
        if (Eth_Pkt_Rdy) begin pkt_cnt = pkt_cnt + 1; pkt_cyc = cyc; end
        if (Err[0]) err0_cnt = err0_cnt + 1;
        if (Err[1]) err1_cnt = err1_cnt + 1;
        if (Err != 2'b00) err_cyc = cyc;
        if (Done[0]) done0_cnt = done0_cnt + 1;
        if (Done[1]) done1_cnt = done1_cnt + 1;
        if (Done != 2'b00) done_cyc_q.push_back(cyc);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
        #1;
    endtask

    task automatic wait_idle(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (!Busy) begin ok = 1'b1; break; end
            tick(1);
        end
    endtask

    task automatic test_reset;
        Rstn = 1'b0; Req0 = 1'b0; Req1 = 1'b0; Len0 = '0; Len1 = '0; Tx_En = 1'b0;
        tick(3);
        if (Rd0 !== 1'b0) $display("FAIL reset_rd0 got=%b exp=0", Rd0); else n_pass++; n_checks++;
        if (Rd1 !== 1'b0) $display("FAIL reset_rd1 got=%b exp=0", Rd1); else n_pass++; n_checks++;
        if (Eth_Byte !== 8'h00) $display("FAIL reset_byte got=%h exp=00", Eth_Byte); else n_pass++; n_checks++;
        if (Eth_Byte_Valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", Eth_Byte_Valid); else n_pass++; n_checks++;
        if (Eth_Pkt_Rdy !== 1'b0) $display("FAIL reset_pktrdy got=%b exp=0", Eth_Pkt_Rdy); else n_pass++; n_checks++;
        if (Done !== 2'b00) $display("FAIL reset_done got=%b exp=00", Done); else n_pass++; n_checks++;
        if (Err !== 2'b00) $display("FAIL reset_err got=%b exp=00", Err); else n_pass++; n_checks++;
        if (Busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", Busy); else n_pass++; n_checks++;
        Rstn = 1'b1;
        tick(2);
    endtask

    task automatic test_basic;
        int r0, r1, nq, p0, errs, nb, last_v, span;
        bit seen;
        logic [1:0] dval;
        r0 = rd0_cnt; r1 = rd1_cnt; nq = out_q.size(); p0 = pkt_cnt; base0 = rd0_pos;
        Len0 = 11'd60; Req0 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin tick(1); if (pkt_cnt != p0) seen = 1'b1; end
        if (seen !== 1'b1) $display("FAIL basic_pkt_timeout got=%b exp=1", seen); else n_pass++; n_checks++;
        if (rd0_cnt - r0 != 60) $display("FAIL basic_rd0_cycles got=%0d exp=60", rd0_cnt - r0); else n_pass++; n_checks++;
        if (rd1_cnt - r1 != 0) $display("FAIL basic_rd1_cycles got=%0d exp=0", rd1_cnt - r1); else n_pass++; n_checks++;
        if (out_q.size() - nq != 60) $display("FAIL basic_nbytes got=%0d exp=60", out_q.size() - nq); else n_pass++; n_checks++;
        errs = 0; last_v = -1; span = -1;
        if (out_q.size() - nq == 60) begin
            for (int i = 0; i < 60; i++) if (out_q[nq + i] !== 8'(i + 1)) errs++;
            last_v = vcyc_q[nq + 59];
            span = vcyc_q[nq + 59] - vcyc_q[nq];
        end else errs = 999;
        if (errs != 0) $display("FAIL basic_data got=%0d_bad_bytes exp=0", errs); else n_pass++; n_checks++;
        if (span != 59) $display("FAIL basic_contig got=%0d exp=59", span); else n_pass++; n_checks++;
        if (pkt_cyc != last_v + 1) $display("FAIL basic_pktrdy_pos got=%0d exp=%0d", pkt_cyc, last_v + 1); else n_pass++; n_checks++;
        if (pkt_cnt - p0 != 1) $display("FAIL basic_pkt_count got=%0d exp=1", pkt_cnt - p0); else n_pass++; n_checks++;
        Tx_En = 1'b1;
        tick(100);
        Tx_En = 1'b0;
        seen = 1'b0; dval = 2'b00;
        for (int i = 0; i < 10 && !seen; i++) begin tick(1); if (Done != 2'b00) begin seen = 1'b1; dval = Done; end end
        Req0 = 1'b0;
        if (dval !== 2'b01) $display("FAIL basic_done got=%b exp=01", dval); else n_pass++; n_checks++;
        nb = 0;
        for (int i = 0; i < 60 && Busy; i++) begin nb++; tick(1); end
        if (nb != 48) $display("FAIL basic_ipg_cycles got=%0d exp=48", nb); else n_pass++; n_checks++;
    endtask

    task automatic test_pad;
        int r0, r1, nq, p0, errs, last_v, span;
        bit seen, ok;
        logic [1:0] dval;
        r0 = rd0_cnt; r1 = rd1_cnt; nq = out_q.size(); p0 = pkt_cnt; base1 = rd1_pos;
        Len1 = 11'd10; Req1 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin tick(1); if (pkt_cnt != p0) seen = 1'b1; end
        if (seen !== 1'b1) $display("FAIL pad_pkt_timeout got=%b exp=1", seen); else n_pass++; n_checks++;
        if (rd1_cnt - r1 != 10) $display("FAIL pad_rd1_cycles got=%0d exp=10", rd1_cnt - r1); else n_pass++; n_checks++;
        if (rd0_cnt - r0 != 0) $display("FAIL pad_rd0_cycles got=%0d exp=0", rd0_cnt - r0); else n_pass++; n_checks++;
        if (out_q.size() - nq != 46) $display("FAIL pad_nbytes got=%0d exp=46", out_q.size() - nq); else n_pass++; n_checks++;
        errs = 0; last_v = -1; span = -1;
        if (out_q.size() - nq == 46) begin
            for (int i = 0; i < 46; i++) if (out_q[nq + i] !== ((i < 10) ? 8'(101 + i) : 8'h00)) errs++;
            last_v = vcyc_q[nq + 45];
            span = vcyc_q[nq + 45] - vcyc_q[nq];
        end else errs = 999;
        if (errs != 0) $display("FAIL pad_data got=%0d_bad_bytes exp=0", errs); else n_pass++; n_checks++;
        if (span != 45) $display("FAIL pad_contig got=%0d exp=45", span); else n_pass++; n_checks++;
        if (pkt_cyc != last_v + 1) $display("FAIL pad_pktrdy_pos got=%0d exp=%0d", pkt_cyc, last_v + 1); else n_pass++; n_checks++;
        Tx_En = 1'b1;
        tick(5);
        Tx_En = 1'b0;
        seen = 1'b0; dval = 2'b00;
        for (int i = 0; i < 10 && !seen; i++) begin tick(1); if (Done != 2'b00) begin seen = 1'b1; dval = Done; end end
        Req1 = 1'b0;
        if (dval !== 2'b10) $display("FAIL pad_done got=%b exp=10", dval); else n_pass++; n_checks++;
        wait_idle(100, ok);
        if (ok !== 1'b1) $display("FAIL pad_idle_timeout got=%b exp=1", ok); else n_pass++; n_checks++;
    endtask

    task automatic test_back_to_back;
        int g0, dq0, p0, min_sep, sep;
        bit seen, ok;
        g0 = gnt_hist.size(); dq0 = done_cyc_q.size();
        Len0 = 11'd50; Len1 = 11'd50; Req0 = 1'b1; Req1 = 1'b1;
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            p0 = pkt_cnt; seen = 1'b0;
            for (int i = 0; i < 300 && !seen; i++) begin tick(1); if (pkt_cnt != p0) seen = 1'b1; end
            if (!seen) ok = 1'b0;
            Tx_En = 1'b1;
            tick(3);
            Tx_En = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin tick(1); if (Done != 2'b00) seen = 1'b1; end
            if (!seen) ok = 1'b0;
        end
        Req0 = 1'b0; Req1 = 1'b0;
        if (ok !== 1'b1) $display("FAIL b2b_timeout got=%b exp=1", ok); else n_pass++; n_checks++;
        if (gnt_hist.size() - g0 != 4) $display("FAIL b2b_ngrants got=%0d exp=4", gnt_hist.size() - g0); else n_pass++; n_checks++;
        for (int k = 0; k < 4; k++) begin
            int got;
            got = (gnt_hist.size() > g0 + k) ? gnt_hist[g0 + k] : -1;
            if (got != (k % 2)) $display("FAIL b2b_order%0d got=%0d exp=%0d", k, got, k % 2); else n_pass++;
            n_checks++;
        end
        min_sep = 9999;
        if (gnt_hist.size() - g0 >= 4 && done_cyc_q.size() - dq0 >= 3) begin
            for (int k = 1; k < 4; k++) begin
                sep = rise_cyc[g0 + k] - done_cyc_q[dq0 + k - 1];
                if (sep < min_sep) min_sep = sep;
            end
        end else min_sep = -1;
        if (min_sep < 49) $display("FAIL b2b_gap got=%0d exp=>=49", min_sep); else n_pass++; n_checks++;
        if (both_rd != 0) $display("FAIL b2b_both_rd got=%0d exp=0", both_rd); else n_pass++; n_checks++;
        wait_idle(100, ok);
        if (ok !== 1'b1) $display("FAIL b2b_idle_timeout got=%b exp=1", ok); else n_pass++; n_checks++;
    endtask

    task automatic test_err;
        int r0, nq, e0, d0, p0, pc;
        bit seen, ok;
        logic [1:0] eval;
        logic [10:0] bad_len [2];
        bad_len[0] = 11'd0; bad_len[1] = 11'd1501;
        for (int t = 0; t < 2; t++) begin
            r0 = rd0_cnt; nq = out_q.size(); e0 = err0_cnt;
            Len0 = bad_len[t]; Req0 = 1'b1;
            seen = 1'b0; eval = 2'b00;
            for (int i = 0; i < 10 && !seen; i++) begin tick(1); if (Err != 2'b00) begin seen = 1'b1; eval = Err; end end
            Req0 = 1'b0;
            if (eval !== 2'b01) $display("FAIL err_len%0d_pulse got=%b exp=01", bad_len[t], eval); else n_pass++; n_checks++;
            tick(4);
            if (rd0_cnt - r0 != 0) $display("FAIL err_len%0d_rd0 got=%0d exp=0", bad_len[t], rd0_cnt - r0); else n_pass++; n_checks++;
            if (out_q.size() - nq != 0) $display("FAIL err_len%0d_valid got=%0d exp=0", bad_len[t], out_q.size() - nq); else n_pass++; n_checks++;
            if (err0_cnt - e0 != 1) $display("FAIL err_len%0d_count got=%0d exp=1", bad_len[t], err0_cnt - e0); else n_pass++; n_checks++;
        end
        d0 = done0_cnt; p0 = pkt_cnt; base0 = rd0_pos;
        Len0 = 11'd20; Req0 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin tick(1); if (pkt_cnt != p0) seen = 1'b1; end
        pc = pkt_cyc;
        if (seen !== 1'b1) $display("FAIL tmo_pkt_timeout got=%b exp=1", seen); else n_pass++; n_checks++;
        seen = 1'b0; eval = 2'b00;
        for (int i = 0; i < 1100 && !seen; i++) begin tick(1); if (Err != 2'b00) begin seen = 1'b1; eval = Err; end end
        Req0 = 1'b0;
        if (eval !== 2'b01) $display("FAIL tmo_err got=%b exp=01", eval); else n_pass++; n_checks++;
        if (err_cyc - pc != 1024) $display("FAIL tmo_cycles got=%0d exp=1024", err_cyc - pc); else n_pass++; n_checks++;
        if (done0_cnt - d0 != 0) $display("FAIL tmo_no_done got=%0d exp=0", done0_cnt - d0); else n_pass++; n_checks++;
        wait_idle(100, ok);
        if (ok !== 1'b1) $display("FAIL tmo_idle_timeout got=%b exp=1", ok); else n_pass++; n_checks++;
    endtask

    task automatic test_reset_mid;
        int r0, p0, g0, got;
        bit seen;
        r0 = rd0_cnt; p0 = pkt_cnt; base0 = rd0_pos;
        Len0 = 11'd60; Req0 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin tick(1); if (rd0_cnt - r0 >= 20) seen = 1'b1; end
        if (seen !== 1'b1) $display("FAIL rstmid_stream_timeout got=%b exp=1", seen); else n_pass++; n_checks++;
        Rstn = 1'b0;
        #1;
        if (Rd0 !== 1'b0) $display("FAIL rstmid_rd0 got=%b exp=0", Rd0); else n_pass++; n_checks++;
        if (Eth_Byte !== 8'h00) $display("FAIL rstmid_byte got=%h exp=00", Eth_Byte); else n_pass++; n_checks++;
        if (Eth_Byte_Valid !== 1'b0) $display("FAIL rstmid_valid got=%b exp=0", Eth_Byte_Valid); else n_pass++; n_checks++;
        if (Busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", Busy); else n_pass++; n_checks++;
        Len0 = 11'd10; Len1 = 11'd10; Req1 = 1'b1;
        tick(3);
        g0 = gnt_hist.size();
        Rstn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin tick(1); if (gnt_hist.size() > g0) seen = 1'b1; end
        got = seen ? gnt_hist[g0] : -1;
        if (got != 0) $display("FAIL rstmid_next_grant got=%0d exp=0", got); else n_pass++; n_checks++;
        if (pkt_cnt - p0 != 0) $display("FAIL rstmid_no_pktrdy got=%0d exp=0", pkt_cnt - p0); else n_pass++; n_checks++;
        if (Rd1 !== 1'b0) $display("FAIL rstmid_rd1 got=%b exp=0", Rd1); else n_pass++; n_checks++;
        Req0 = 1'b0; Req1 = 1'b0;
        tick(5);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pad();
        test_back_to_back();
        test_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
